spi_byte_writer: RTL and testbench
==================================

# spi_byte_writer

SPI slave transmitter (mode 0, MSB first) that returns response bytes to the external SPI master on `miso`. It is the outbound counterpart of the SPI receive path and shares its `cs`/`sck` pins. Internal logic pushes bytes into a small FIFO; the block shifts them out byte by byte while `cs` is asserted, and substitutes a fill byte when the FIFO runs dry. All pin inputs are synchronised into the `clock` domain.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `FILL_BYTE`, 8'hFF: byte transmitted when the FIFO is empty at a byte boundary.

- `clock`  in  1  system clock; must be ≥8× the SCK frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  raw chip select from the pin, active-low.
- `sck`  in  1  raw SPI clock from the pin.
- `tx_data`  in  8  byte to queue.
- `tx_valid`  in  1  push request; accepted on a cycle where `tx_valid && tx_ready`.
- `tx_ready`  out  1  FIFO not full.
- `miso`  out  1  serial data out, equal to `shift[7]`.
- `miso_oe`  out  1  output enable for the `miso` pad; high while synchronised `cs` is low.
- `byte_sent`  out  1  one-cycle pulse when the 8th SCK rising edge of a byte is seen.
- `underrun`  out  1  one-cycle pulse when `FILL_BYTE` is loaded because the FIFO is empty.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchronisers and edge detect**
  - `cs` and `sck` each pass through a 2-flop synchroniser, then a registered previous-value edge detect.
  - This produces `cs_fall`, `cs_rise`, `sck_rise` and `sck_fall`.
- **FIFO**
  - DEPTH-entry circular buffer with wrapping read/write pointers and a `count` register.
  - Push when `tx_valid && tx_ready`. A push while full is ignored and the data is dropped.
  - `tx_ready = (count != DEPTH)`, computed from `count` only. A pop in the same cycle does not free a slot for that cycle's push.
  - A simultaneous push and pop leaves `count` unchanged.
  - A pop on an empty FIFO returns `FILL_BYTE` and pulses `underrun`. A push in that same cycle is still written.
- **Load**
  - Pop one byte (or take `FILL_BYTE`) into `shift[7:0]` and clear `bit_cnt`.
- **FSM: IDLE**
  - `miso_oe = 0`.
  - On `cs_fall`: load, then go to SHIFT.
- **FSM: SHIFT**
  - `miso_oe = 1`.
  - On `sck_rise`: `bit_cnt <= bit_cnt + 1` (3 bits, wraps). If `bit_cnt == 7`, pulse `byte_sent` and set `boundary`.
  - On `sck_fall`: if `boundary`, load the next byte and clear `boundary`; otherwise `shift <= {shift[6:0], 1'b0}`.
  - On `cs_rise`: go to IDLE and clear `bit_cnt` and `boundary`. The partial byte is discarded, not re-queued, and no `byte_sent` is issued. FIFO contents are kept.
- **Event priority**
  - `cs_rise` takes priority over any SCK edge in the same cycle.
  - `sck_rise` and `sck_fall` in one cycle cannot occur under the clock-ratio rule.
- **Reset values** (asynchronous, `reset` low)
  - FIFO empty; pointers and `count` = 0; `fifo_count` = 0; `tx_ready` = 1.
  - `shift` = 0, so `miso` = 0; `miso_oe` = 0.
  - `byte_sent` = 0, `underrun` = 0; state IDLE.
  - Synchroniser flops reset to `cs` = 1 and `sck` = 0, so no spurious edges leave reset.
  - A reset in the middle of a transfer aborts it immediately.

## Timing
- Pin `cs` falling to valid `miso` MSB and `miso_oe` = 1: 3 clocks (2 sync + 1 register).
- The master must allow ≥4 clocks between `cs` falling and the first SCK rising edge.
- Pin `sck` falling to new `miso` bit: 3 clocks. This fits within the SCK low phase given the ≥8× clock ratio.
- Pin `sck` rising (8th) to `byte_sent`: 3 clocks.
- Push to `fifo_count` update: 1 clock. The pushed byte is eligible at the next load event after that.
- Pin `cs` rising to `miso_oe` = 0: 3 clocks.

## Test plan
- Push 8'hA5 and 8'h3C, assert `cs`, clock 16 SCK cycles. Master samples A5 then 3C. `byte_sent` pulses twice, `fifo_count` ends at 0, `underrun` stays 0.
- Empty FIFO, one 8-bit transfer: master samples 8'hFF, `underrun` pulses once (at the `cs_fall` load), `byte_sent` pulses once.
- Push 5 bytes with DEPTH=4: `tx_ready` drops after the 4th push, the 5th is dropped, `fifo_count` = 4. A transfer returns only the first 4 bytes, then 8'hFF.
- Push 8'h81 and 8'h42, send 3 SCK cycles, deassert `cs`. No `byte_sent`, `miso_oe` falls 3 clocks later. The next transfer returns 8'h42 (0x81 is lost).
- Assert `reset` low in the middle of a byte with 2 bytes queued: `miso_oe` = 0 and `fifo_count` = 0 immediately. The next transfer returns 8'hFF with an `underrun` pulse.
- Continuous push at the sustained rate during a 4-byte burst: back-to-back bytes arrive with no gap and no `underrun`. `fifo_count` never exceeds DEPTH.

Source files
------------

// File: rtl/spi_byte_writer.sv
// SPI mode-0 slave transmitter: queues response bytes in a small FIFO and shifts them out
// MSB first on miso while cs is low, substituting FILL_BYTE when the FIFO runs dry.
module spi_byte_writer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     sck,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     miso,
  output logic                     miso_oe,
  output logic                     byte_sent,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state_q, state_d;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          fifo_empty, push, pop, load;

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       boundary_q, boundary_d;
  logic       byte_sent_q, byte_sent_d;
  logic       underrun_q, underrun_d;

  // Sync flops reset to the idle pin levels so leaving reset produces no edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      cs_meta_q  <= cs;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      sck_meta_q <= sck;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
    end
  end

  assign cs_fall  =  cs_prev_q  & ~cs_sync_q;
  assign cs_rise  = ~cs_prev_q  &  cs_sync_q;
  assign sck_rise = ~sck_prev_q &  sck_sync_q;
  assign sck_fall =  sck_prev_q & ~sck_sync_q;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != FullCount);
  assign push       = tx_valid && tx_ready;
  assign pop        = load && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    boundary_d  = boundary_q;
    byte_sent_d = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d    = StIdle;
          bit_cnt_d  = 3'd0;
          boundary_d = 1'b0;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_sent_d = 1'b1;
            boundary_d  = 1'b1;
          end
        end else if (sck_fall) begin
          if (boundary_q) begin
            load       = 1'b1;
            boundary_d = 1'b0;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      shift_d   = fifo_empty ? FILL_BYTE : mem_q[rd_ptr_q];
      bit_cnt_d = 3'd0;
    end
    underrun_d = load && fifo_empty;
  end

  // A push that coincides with a pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      boundary_q  <= 1'b0;
      byte_sent_q <= 1'b0;
      underrun_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      boundary_q  <= boundary_d;
      byte_sent_q <= byte_sent_d;
      underrun_q  <= underrun_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign miso       = shift_q[7];
  assign miso_oe    = (state_q == StShift);
  assign byte_sent  = byte_sent_q;
  assign underrun   = underrun_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_spi_byte_writer.sv
// Bench for spi_byte_writer: a bit-banged SPI master with a queue-based FIFO model feeding
// an expected-byte scoreboard that a byte_sent-driven monitor drains.
module tb_spi_byte_writer;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  FILL  = 8'hFF;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs, sck;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, miso, miso_oe, byte_sent, underrun;
  logic [2:0] fifo_count;

  spi_byte_writer #(.DEPTH(DEPTH), .FILL_BYTE(FILL)) dut (
    .clock      (clock),
    .reset      (reset),
    .cs         (cs),
    .sck        (sck),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .byte_sent  (byte_sent),
    .underrun   (underrun),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int exp_underruns = 0;
  int exp_sent = 0;
  int underrun_cnt = 0;
  int sent_cnt = 0;
  bit over_flag = 1'b0;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clock) begin
    if (byte_sent) begin
      sent_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL byte: got %0h expected none at %0t", last_rx, $time);
      end else begin
        check("byte", int'(last_rx), int'(exp_q.pop_front()));
      end
    end
    if (underrun) underrun_cnt++;
    if (fifo_count > 3'(DEPTH)) over_flag = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // The model takes a byte whenever the DUT is expected to load one.
  task automatic model_load();
    if (model_q.size() > 0) begin
      exp_q.push_back(model_q.pop_front());
    end else begin
      exp_q.push_back(FILL);
      exp_underruns++;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bit acc;
    acc = (model_q.size() < DEPTH);
    check("tx_ready", int'(tx_ready), int'(acc));
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    if (acc) model_q.push_back(d);
  endtask

  // Master: nbytes full bytes, then optionally a partial byte that is aborted by cs rising.
  task automatic xfer(input int nbytes, input int partial, input bit push_mid);
    logic [7:0] rx;
    rx = 8'h00;
    cs = 1'b0;
    model_load();
    wait_clk(2);
    check("oe_before", int'(miso_oe), 0);
    wait_clk(1);
    check("oe_after", int'(miso_oe), 1);
    wait_clk(3);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        rx  = {rx[6:0], miso};
        sck = 1'b1;
        if (i == 7) last_rx = rx;
        wait_clk(6);
        if (b == nbytes - 1 && i == 7 && partial == 0) begin
          cs  = 1'b1;
          sck = 1'b0;
        end else begin
          sck = 1'b0;
          if (i == 7) model_load();
        end
        if (push_mid && i == 3) begin
          wait_clk(2);
          push_byte(8'($urandom));
          wait_clk(3);
        end else begin
          wait_clk(6);
        end
      end
    end
    exp_sent += nbytes;
    if (partial > 0) begin
      for (int i = 0; i < partial; i++) begin
        sck = 1'b1;
        wait_clk(6);
        sck = 1'b0;
        wait_clk(6);
      end
      cs = 1'b1;
      void'(exp_q.pop_back());
      wait_clk(2);
      check("oe_hold", int'(miso_oe), 1);
      wait_clk(1);
      check("oe_drop", int'(miso_oe), 0);
    end
    wait_clk(6);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_count"}, int'(fifo_count), model_q.size());
    check({tag, "_underruns"}, underrun_cnt, exp_underruns);
    check({tag, "_sent"}, sent_cnt, exp_sent);
  endtask

  initial begin
    reset = 1'b0;
    cs = 1'b1;
    sck = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    wait_clk(3);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_miso", int'(miso), 0);
    check("rst_oe", int'(miso_oe), 0);
    check("rst_pulses", int'({byte_sent, underrun}), 0);
    reset = 1'b1;
    wait_clk(3);

    // Two queued bytes, cs released with the final falling edge so nothing more loads.
    push_byte(8'hA5);
    push_byte(8'h3C);
    check("count_two", int'(fifo_count), 2);
    xfer(2, 0, 1'b0);
    check_totals("basic");

    // Empty FIFO returns the fill byte.
    xfer(1, 0, 1'b0);
    check_totals("empty");

    // Overfill: the fifth push is dropped.
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    check("full_ready", int'(tx_ready), 0);
    check("full_count", int'(fifo_count), 4);
    xfer(5, 0, 1'b0);
    check_totals("overfill");

    // Aborted byte is lost; next transfer returns the following byte.
    push_byte(8'h81);
    push_byte(8'h42);
    xfer(0, 3, 1'b0);
    check("abort_sent", sent_cnt, exp_sent);
    xfer(1, 0, 1'b0);
    check_totals("abort");

    // Sustained refill during a 4-byte burst.
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    xfer(4, 0, 1'b1);
    check_totals("stream");
    check("no_overflow", int'(over_flag), 0);
    xfer(2, 0, 1'b0);
    check_totals("drain");

    // Reset in the middle of a byte.
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    cs = 1'b0;
    model_load();
    wait_clk(6);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1;
      wait_clk(6);
      sck = 1'b0;
      wait_clk(6);
    end
    sck = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    #1;
    check("midrst_oe", int'(miso_oe), 0);
    check("midrst_count", int'(fifo_count), 0);
    void'(exp_q.pop_back());
    model_q.delete();
    cs = 1'b1;
    sck = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(3);
    xfer(1, 0, 1'b0);
    check_totals("post_reset");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
